// File: rtl/itlb_refill_ctrl_pkg.sv
// Shared Sv32 ITLB constants and the refill controller state encoding.
package itlb_refill_ctrl_pkg;

    localparam int unsigned IDX_W = 5;   // 32 ITLB entries, matches ilru
    localparam int unsigned VPN_W = 20;  // Sv32 virtual page number
    localparam int unsigned PPN_W = 22;  // Sv32 physical page number
    localparam int unsigned CNT_W = 8;   // response timeout counter width

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StVictim   = 3'd1,
        StCapture  = 3'd2,
        StReq      = 3'd3,
        StWaitResp = 3'd4,
        StDrain    = 3'd5,
        StWrite    = 3'd6,
        StDone     = 3'd7
    } refill_state_e;

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// Page-table walker port: request handshake plus single-cycle response pulse.
interface itlb_refill_ctrl_if;
    import itlb_refill_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [VPN_W-1:0] req_vpn;
    logic             resp_valid;
    logic [PPN_W-1:0] resp_ppn;
    logic             resp_fault;

    // master: refill controller, slave: PTW arbiter port
    modport master (
        output req_valid, req_vpn,
        input  req_ready, resp_valid, resp_ppn, resp_fault
    );
    modport slave (
        input  req_valid, req_vpn,
        output req_ready, resp_valid, resp_ppn, resp_fault
    );

endinterface

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss sequencer: victim query, PTW walk, entry install and LRU touch.
// Every output is decoded from state or held registers, never from inputs.
module itlb_refill_ctrl
    import itlb_refill_ctrl_pkg::*;
#(
    parameter int unsigned Timeout = 255  // WAIT_RESP cycles before forced fault (1..255)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lkp_valid,
    input  logic                       lkp_hit,
    input  logic [IDX_W-1:0]           lkp_hit_idx,
    input  logic [VPN_W-1:0]           lkp_vpn,
    input  logic                       flush,
    output logic                       lru_access,
    output logic [IDX_W-1:0]           lru_addr_acc,
    output logic                       lru_compare,
    input  logic [IDX_W-1:0]           lru_victim,
    itlb_refill_ctrl_if.master         ptw,
    output logic                       tlb_we,
    output logic [IDX_W-1:0]           tlb_widx,
    output logic [VPN_W-1:0]           tlb_wvpn,
    output logic [PPN_W-1:0]           tlb_wppn,
    output logic                       busy,
    output logic                       refill_done,
    output logic                       refill_fault
);

    // Timeout fires in the cycle where the incremented count would reach Timeout.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(Timeout - 1);

    refill_state_e    state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [IDX_W-1:0] victim_q, victim_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             touch_q, touch_d;
    logic [IDX_W-1:0] touch_idx_q, touch_idx_d;
    logic             fault_q, fault_d;

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            vpn_q       <= '0;
            victim_q    <= '0;
            ppn_q       <= '0;
            cnt_q       <= '0;
            touch_q     <= 1'b0;
            touch_idx_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            victim_q    <= victim_d;
            ppn_q       <= ppn_d;
            cnt_q       <= cnt_d;
            touch_q     <= touch_d;
            touch_idx_q <= touch_idx_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state, capture and one-shot pulse decisions.
    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        victim_d    = victim_q;
        ppn_d       = ppn_q;
        cnt_d       = cnt_q;
        touch_d     = 1'b0;
        touch_idx_d = touch_idx_q;
        fault_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (lkp_valid) begin
                    if (lkp_hit) begin
                        touch_d     = 1'b1;
                        touch_idx_d = lkp_hit_idx;
                    end else begin
                        vpn_d   = lkp_vpn;
                        state_d = StVictim;
                    end
                end
            end
            StVictim: state_d = flush ? StIdle : StCapture;
            StCapture: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    victim_d = lru_victim;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (ptw.req_ready) begin
                    // Once accepted a response is owed, so a flush must drain it.
                    cnt_d   = '0;
                    state_d = flush ? StDrain : StWaitResp;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWaitResp: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) begin
                    // A response arriving with the flush is already consumed.
                    state_d = ptw.resp_valid ? StIdle : StDrain;
                end else if (ptw.resp_valid) begin
                    if (ptw.resp_fault) begin
                        fault_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ppn_d   = ptw.resp_ppn;
                        state_d = StWrite;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    fault_d = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: if (ptw.resp_valid) state_d = StIdle;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered-source output decode.
    always_comb begin
        lru_compare   = (state_q == StVictim);
        lru_access    = touch_q || (state_q == StWrite);
        lru_addr_acc  = (state_q == StWrite) ? victim_q : (touch_q ? touch_idx_q : '0);
        ptw.req_valid = (state_q == StReq);
        ptw.req_vpn   = vpn_q;
        tlb_we        = (state_q == StWrite);
        tlb_widx      = victim_q;
        tlb_wvpn      = vpn_q;
        tlb_wppn      = ppn_q;
        busy          = (state_q != StIdle);
        refill_done   = (state_q == StDone);
        refill_fault  = fault_q;
    end

endmodule
